// File: rtl/psum_accum_pkg.sv
// Shared definitions for the partial-sum accumulator.
package psum_accum_pkg;

    localparam int unsigned BW      = 8;
    localparam int unsigned BW_PSUM = 2 * BW + 4;
    localparam int unsigned ACC_EXT = 4;
    localparam int unsigned ACC_BW  = BW_PSUM + ACC_EXT;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Sign-extend an incoming partial sum to accumulator width.
    function automatic logic signed [ACC_BW-1:0] sext(input logic signed [BW_PSUM-1:0] p);
        return {{ACC_EXT{p[BW_PSUM-1]}}, p};
    endfunction

endpackage

// File: rtl/psum_accum.sv
// Temporal accumulator: sums cfg_len consecutive MAC partial sums into one
// wider result, optionally ReLU-clamped, and holds it on a valid/ready output.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int unsigned bw      = BW,
    parameter int unsigned bw_psum = 2 * bw + 4,
    parameter int unsigned acc_ext = ACC_EXT,
    parameter int unsigned acc_bw  = bw_psum + acc_ext
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [acc_ext:0]          cfg_len,
    input  logic                      cfg_relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [bw_psum-1:0] in_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [acc_bw-1:0]  out_sum,
    output logic                      busy
);

    localparam logic [acc_ext:0] LEN_MAX = (acc_ext + 1)'(1 << acc_ext);

    state_t                    state, state_nxt;
    logic signed [acc_bw-1:0]  acc;
    logic [acc_ext:0]          cnt;
    logic [acc_ext:0]          len_q;
    logic                      relu_q;

    logic                      accept;
    logic                      xfer;
    logic                      finalise;
    logic [acc_ext:0]          len_clamped;
    logic [acc_ext:0]          len_eff;
    logic                      relu_eff;
    logic signed [acc_bw-1:0]  sum;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign busy     = (state == ACC);

    // Group length/ReLU come straight from cfg_* on the first beat (IDLE keeps
    // cnt at 0), so one end-of-group compare serves both states.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0)
            len_clamped = (acc_ext + 1)'(1);
        else if (cfg_len > LEN_MAX)
            len_clamped = LEN_MAX;

        len_eff   = (state == IDLE) ? len_clamped : len_q;
        relu_eff  = (state == IDLE) ? cfg_relu    : relu_q;
        sum       = (state == IDLE) ? sext(in_psum) : acc + sext(in_psum);
        finalise  = accept && (cnt == len_eff - (acc_ext + 1)'(1));

        state_nxt = state;
        if (accept)
            state_nxt = finalise ? IDLE : ACC;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Accumulator, beat counter, latched group configuration.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            relu_q <= 1'b0;
        end else if (accept) begin
            acc <= sum;
            cnt <= finalise ? '0 : cnt + (acc_ext + 1)'(1);
            if (state == IDLE) begin
                len_q  <= len_clamped;
                relu_q <= cfg_relu;
            end
        end
    end

    // Output register: a finalise reloads it even while the old result leaves.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (finalise) begin
            out_sum   <= (relu_eff && sum[acc_bw-1]) ? '0 : sum;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Directed self-checking bench for psum_accum.
module tb_psum_accum;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [4:0]         cfg_len;
    logic               cfg_relu;
    logic               in_valid;
    logic               in_ready;
    logic signed [19:0] in_psum;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_sum;
    logic               busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    psum_accum dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_len   (cfg_len),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [19:0] p);
        in_valid = 1'b1;
        in_psum  = p;
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        cfg_len   = '0;
        cfg_relu  = 1'b0;
        in_valid  = 1'b0;
        in_psum   = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 24'(out_valid), 24'd0);
        check("rst_out_sum",   out_sum,        24'd0);
        check("rst_busy",      24'(busy),      24'd0);
        check("rst_in_ready",  24'(in_ready),  24'd1);
        reset_n = 1'b1;
        step();

        // len=4: 100 - 50 + 25 + 5 = 80
        cfg_len = 5'd4; cfg_relu = 1'b0;
        beat(20'sd100);
        check("g4_busy_b2", 24'(busy), 24'd1);
        beat(-20'sd50);
        check("g4_busy_b3", 24'(busy), 24'd1);
        beat(20'sd25);
        check("g4_busy_b4", 24'(busy), 24'd1);
        check("g4_no_early_valid", 24'(out_valid), 24'd0);
        beat(20'sd5);
        in_valid = 1'b0;
        check("g4_valid", 24'(out_valid), 24'd1);
        check("g4_sum",   out_sum,        24'd80);
        check("g4_idle",  24'(busy),      24'd0);
        step();
        check("g4_cleared", 24'(out_valid), 24'd0);

        // len=2, relu=1: -300 + 100 = -200 -> 0; cfg change mid-group ignored
        cfg_len = 5'd2; cfg_relu = 1'b1;
        beat(-20'sd300);
        cfg_relu = 1'b0; cfg_len = 5'd4;
        beat(20'sd100);
        in_valid = 1'b0;
        check("relu_valid", 24'(out_valid), 24'd1);
        check("relu_sum",   out_sum,        24'd0);
        step();

        // len=2, relu=0: -200
        cfg_len = 5'd2; cfg_relu = 1'b0;
        beat(-20'sd300);
        beat(20'sd100);
        in_valid = 1'b0;
        check("norelu_sum", out_sum, 24'hFFFF38);
        step();

        // 16 extreme negative beats: no wrap
        cfg_len = 5'd16;
        for (int i = 0; i < 16; i++) beat(-20'sd262144);
        in_valid = 1'b0;
        check("max_neg_valid", 24'(out_valid), 24'd1);
        check("max_neg_sum",   out_sum,        24'hC00000);
        step();

        // cfg_len=31 clamps to 16
        cfg_len = 5'd31;
        for (int i = 0; i < 15; i++) beat(20'sd262143);
        check("clamp_not_done", 24'(out_valid), 24'd0);
        beat(20'sd262143);
        in_valid = 1'b0;
        check("max_pos_sum", out_sum, 24'd4194288);
        step();

        // Backpressure: A = 1 + 2 held, B = 3 + 4 stalls then proceeds
        out_ready = 1'b0;
        cfg_len = 5'd2;
        beat(20'sd1);
        beat(20'sd2);
        check("bp_a_valid",    24'(out_valid), 24'd1);
        check("bp_a_sum",      out_sum,        24'd3);
        check("bp_in_ready_0", 24'(in_ready),  24'd0);
        beat(20'sd3);
        beat(20'sd3);
        check("bp_hold_sum",  out_sum,   24'd3);
        check("bp_hold_busy", 24'(busy), 24'd0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_1", 24'(in_ready), 24'd1);
        beat(20'sd3);
        check("bp_a_taken", 24'(out_valid), 24'd0);
        check("bp_b_busy",  24'(busy),      24'd1);
        beat(20'sd4);
        in_valid = 1'b0;
        check("bp_b_valid", 24'(out_valid), 24'd1);
        check("bp_b_sum",   out_sum,        24'd7);
        step();
        check("bp_b_taken", 24'(out_valid), 24'd0);

        // len 0/1 alternating at full rate: one result per cycle
        for (int i = 1; i <= 8; i++) begin
            cfg_len = (i % 2 == 1) ? 5'd0 : 5'd1;
            check("tp_in_ready", 24'(in_ready), 24'd1);
            beat(20'(i));
            check("tp_valid", 24'(out_valid), 24'd1);
            check("tp_sum",   out_sum,        24'(i));
        end
        in_valid = 1'b0;
        step();

        // Reset mid-group discards the partial sum
        cfg_len = 5'd4;
        beat(20'sd10);
        beat(20'sd20);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        check("mr_busy",  24'(busy),      24'd0);
        check("mr_valid", 24'(out_valid), 24'd0);
        cfg_len = 5'd2;
        beat(20'sd5);
        check("mr_no_stale", 24'(out_valid), 24'd0);
        beat(20'sd6);
        in_valid = 1'b0;
        check("mr_valid2", 24'(out_valid), 24'd1);
        check("mr_sum",    out_sum,        24'd11);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
